axil_ctrl_regs: RTL and testbench

Parametrised AXI4-Lite slave register block for the HPU control plane. It replaces the fixed three-bit control register and the hard-wired n-gram, item-count and loop-bound constants with a programmable register file. Features: byte-strobe writes, a read-only status word, a hardware auto-clear for `matw`, a one-cycle run-start pulse, and SLVERR responses for unmapped addresses. It sits between the PS AXI-Lite master and the stream/exec controllers.

---
 rtl/axil_ctrl_regs.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_axil_ctrl_regs.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_ctrl_regs.sv
// axil_ctrl_regs: AXI4-Lite slave register file for the HPU control plane.
// Holds CTRL (matw/run/last), a live STATUS word and NUM_PARAM parameters.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN   clock, async active-low reset
//   S_AXI_AW*/W*/B*             AXI-Lite write address, data, response
//   S_AXI_AR*/R*                AXI-Lite read address, data
//   status_i                    live status word, returned at index 1
//   matw_clr_i                  pulse clearing CTRL[0] (software wins)
//   matw_o, run_o, last_o       CTRL[0], CTRL[1], CTRL[2]
//   run_start_o                 one-cycle pulse after run_o rises
//   param_o                     PARAM k at bits [32k+31:32k]
module axil_ctrl_regs #(
    parameter int ADDR_W    = 12,
    parameter int NUM_PARAM = 4
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic [ADDR_W-1:0]       S_AXI_AWADDR,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [31:0]             S_AXI_WDATA,
    input  logic [3:0]              S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_W-1:0]       S_AXI_ARADDR,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [31:0]             S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    input  logic [31:0]             status_i,
    input  logic                    matw_clr_i,
    output logic                    matw_o,
    output logic                    run_o,
    output logic                    last_o,
    output logic                    run_start_o,
    output logic [NUM_PARAM*32-1:0] param_o
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [31:0] IDX_END = 32'(NUM_PARAM + 2);

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    wstate_t wstate;
    rstate_t rstate;

    logic [IDX_W-1:0] aw_idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;
    logic             awready_q;
    logic             wready_q;
    logic             bvalid_q;
    logic [1:0]       bresp_q;

    logic             arready_q;
    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic [1:0]       rresp_q;

    logic [2:0]       ctrl_q;
    logic [31:0]      param_q [NUM_PARAM];
    logic             run_prev_q;
    logic             run_start_q;

    // Address bits [1:0] are byte offsets inside a word and never decode.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // ------------------------------------------------------------
    // Write commit: merges the live channel with whatever half of
    // the transfer was latched earlier (address in W_ADDR, data in
    // W_DATA), so the update lands on the edge of the second half.
    // ------------------------------------------------------------
    logic                 aw_hs;
    logic                 w_hs;
    logic                 wr_commit;
    logic [IDX_W-1:0]     wr_idx;
    logic [31:0]          wr_widx;
    logic [31:0]          wr_data;
    logic [3:0]           wr_strb;
    logic [31:0]          wr_mask;
    logic                 wr_ctrl;
    logic                 wr_ok;
    logic [NUM_PARAM-1:0] wr_param;
    logic [2:0]           ctrl_wval;

    assign aw_hs = S_AXI_AWVALID & awready_q;
    assign w_hs  = S_AXI_WVALID & wready_q;

    always_comb begin
        wr_commit = 1'b0;
        wr_idx    = aw_idx_q;
        wr_data   = wdata_q;
        wr_strb   = wstrb_q;
        unique case (wstate)
            W_IDLE: begin
                wr_commit = aw_hs & w_hs;
                wr_idx    = S_AXI_AWADDR[ADDR_W-1:2];
                wr_data   = S_AXI_WDATA;
                wr_strb   = S_AXI_WSTRB;
            end
            W_ADDR: begin
                wr_commit = w_hs;
                wr_data   = S_AXI_WDATA;
                wr_strb   = S_AXI_WSTRB;
            end
            W_DATA: begin
                wr_commit = aw_hs;
                wr_idx    = S_AXI_AWADDR[ADDR_W-1:2];
            end
            W_RESP: begin
                wr_commit = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < 4; b++) begin
            wr_mask[8*b +: 8] = {8{wr_strb[b]}};
        end
    end

    assign wr_widx = 32'(wr_idx);

    // STATUS (index 1) and anything past the last PARAM are errors.
    assign wr_ok = (wr_widx == 32'd0) ||
                   ((wr_widx >= 32'd2) && (wr_widx < IDX_END));

    assign wr_ctrl = wr_commit && (wr_widx == 32'd0);

    always_comb begin
        wr_param = '0;
        for (int k = 0; k < NUM_PARAM; k++) begin
            wr_param[k] = wr_commit && (wr_widx == 32'(k + 2));
        end
    end

    assign ctrl_wval = (ctrl_q & ~wr_mask[2:0]) |
                       (wr_data[2:0] & wr_mask[2:0]);

    // ------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wstate    <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        wstate    <= W_RESP;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                    end else if (aw_hs) begin
                        wstate    <= W_ADDR;
                        awready_q <= 1'b0;
                        aw_idx_q  <= S_AXI_AWADDR[ADDR_W-1:2];
                    end else if (w_hs) begin
                        wstate    <= W_DATA;
                        wready_q  <= 1'b0;
                        wdata_q   <= S_AXI_WDATA;
                        wstrb_q   <= S_AXI_WSTRB;
                    end
                end
                W_ADDR: begin
                    if (w_hs) begin
                        wstate   <= W_RESP;
                        wready_q <= 1'b0;
                    end
                end
                W_DATA: begin
                    if (aw_hs) begin
                        wstate    <= W_RESP;
                        awready_q <= 1'b0;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        wstate    <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
            endcase
            if (wr_commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? 2'b00 : 2'b10;
            end
        end
    end

    // ------------------------------------------------------------
    // Register file. A committing CTRL write overrides matw_clr_i.
    // ------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_q <= 3'b000;
        end else if (wr_ctrl) begin
            ctrl_q <= ctrl_wval;
        end else if (matw_clr_i) begin
            ctrl_q[0] <= 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int k = 0; k < NUM_PARAM; k++) begin
                param_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_PARAM; k++) begin
                if (wr_param[k]) begin
                    param_q[k] <= (param_q[k] & ~wr_mask) |
                                  (wr_data & wr_mask);
                end
            end
        end
    end

    // run_start fires one cycle after run_o is first seen high.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            run_prev_q  <= 1'b0;
            run_start_q <= 1'b0;
        end else begin
            run_prev_q  <= ctrl_q[1];
            run_start_q <= ctrl_q[1] & ~run_prev_q;
        end
    end

    // ------------------------------------------------------------
    // Read decode. Uses current register state, so a read on the
    // same edge as a write commit returns the pre-write value.
    // ------------------------------------------------------------
    logic [31:0] rd_widx;
    logic        rd_is_ctrl;
    logic        rd_is_stat;
    logic        rd_is_param;
    logic [31:0] rd_param;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;

    assign rd_widx     = 32'(S_AXI_ARADDR[ADDR_W-1:2]);
    assign rd_is_ctrl  = (rd_widx == 32'd0);
    assign rd_is_stat  = (rd_widx == 32'd1);
    assign rd_is_param = (rd_widx >= 32'd2) && (rd_widx < IDX_END);

    always_comb begin
        rd_param = '0;
        for (int k = 0; k < NUM_PARAM; k++) begin
            if (rd_widx == 32'(k + 2)) begin
                rd_param = param_q[k];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_resp = 2'b00;
        unique case (1'b1)
            rd_is_ctrl:  rd_data = {29'd0, ctrl_q};
            rd_is_stat:  rd_data = status_i;
            rd_is_param: rd_data = rd_param;
            default:     rd_resp = 2'b10;
        endcase
    end

    // ------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rstate    <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        rstate    <= R_DATA;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_data;
                        rresp_q   <= rd_resp;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rstate    <= R_IDLE;
                        arready_q <= 1'b1;
                        rvalid_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign matw_o      = ctrl_q[0];
    assign run_o       = ctrl_q[1];
    assign last_o      = ctrl_q[2];
    assign run_start_o = run_start_q;

    for (genvar g = 0; g < NUM_PARAM; g++) begin : g_param
        assign param_o[32*g +: 32] = param_q[g];
    end

endmodule

// File: tb/tb_axil_ctrl_regs.sv
// tb_axil_ctrl_regs: directed bench for axil_ctrl_regs.
// Table of single transfers plus hand sequences for multi-cycle cases.
module tb_axil_ctrl_regs;

    logic         clk;
    logic         rst_n;
    logic [11:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [11:0]  araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [31:0]  status;
    logic         matw_clr;
    logic         matw_o;
    logic         run_o;
    logic         last_o;
    logic         run_start_o;
    logic [127:0] param_o;

    int checks = 0;
    int errors = 0;
    int rs_cnt = 0;

    axil_ctrl_regs #(.ADDR_W(12), .NUM_PARAM(4)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .status_i      (status),
        .matw_clr_i    (matw_clr),
        .matw_o        (matw_o),
        .run_o         (run_o),
        .last_o        (last_o),
        .run_start_o   (run_start_o),
        .param_o       (param_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (run_start_o) rs_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [1:0] resp);
        bit aw_ok, w_ok, aw_now, w_now;
        int n;
        @(negedge clk);
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        aw_ok = 0; w_ok = 0; n = 0;
        while (!(aw_ok && w_ok) && n < 20) begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            @(negedge clk);
            if (aw_now) begin awvalid = 1'b0; aw_ok = 1; end
            if (w_now)  begin wvalid = 1'b0; w_ok = 1; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        chk("b_timeout", 128'(bvalid), 128'(1));
        resp = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d,
                      output logic [1:0] r);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        chk("r_timeout", 128'(rvalid), 128'(1));
        d = rdata; r = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        int rs_base;

        tbl[0]  = '{0, 12'h008, 32'h0,        4'h0, 2'b00, 32'h0};
        tbl[1]  = '{1, 12'h00C, 32'hAAAAAAAA, 4'hF, 2'b00, 32'h0};
        tbl[2]  = '{1, 12'h00C, 32'h55555555, 4'h5, 2'b00, 32'h0};
        tbl[3]  = '{0, 12'h00C, 32'h0,        4'h0, 2'b00, 32'hAA55AA55};
        tbl[4]  = '{1, 12'h004, 32'h00001234, 4'hF, 2'b10, 32'h0};
        tbl[5]  = '{0, 12'h004, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        tbl[6]  = '{0, 12'h3FC, 32'h0,        4'h0, 2'b10, 32'h0};
        tbl[7]  = '{1, 12'h014, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
        tbl[8]  = '{0, 12'h014, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
        tbl[9]  = '{1, 12'h018, 32'h99999999, 4'hF, 2'b10, 32'h0};
        tbl[10] = '{0, 12'h018, 32'h0,        4'h0, 2'b10, 32'h0};
        tbl[11] = '{1, 12'h000, 32'hFFFFFFF8, 4'hF, 2'b00, 32'h0};
        tbl[12] = '{1, 12'h000, 32'h00000007, 4'h0, 2'b00, 32'h0};
        tbl[13] = '{0, 12'h000, 32'h0,        4'h0, 2'b00, 32'h0};

        rst_n = 1'b0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
        bready = 0; araddr = '0; arvalid = 0; rready = 0;
        status = 32'hDEADBEEF; matw_clr = 0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_awready", 128'(awready), 128'(1));
        chk("rst_wready", 128'(wready), 128'(1));
        chk("rst_arready", 128'(arready), 128'(1));
        chk("rst_bvalid", 128'(bvalid), 128'(0));
        chk("rst_rvalid", 128'(rvalid), 128'(0));
        chk("rst_resp", 128'({bresp, rresp}), 128'(0));
        chk("rst_rdata", 128'(rdata), 128'(0));
        chk("rst_ctrl", 128'({last_o, run_o, matw_o, run_start_o}), 128'(0));
        chk("rst_param", param_o, 128'(0));
        rst_n = 1'b1;

        // table-driven transfers
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) begin
                wr(tbl[i].addr, tbl[i].data, tbl[i].strb, r);
                chk($sformatf("vec%0d_bresp", i), 128'(r), 128'(tbl[i].resp));
            end else begin
                rd(tbl[i].addr, d, r);
                chk($sformatf("vec%0d_rdata", i), 128'(d), 128'(tbl[i].rdata));
                chk($sformatf("vec%0d_rresp", i), 128'(r), 128'(tbl[i].resp));
            end
        end
        chk("tbl_param1", 128'(param_o[63:32]), 128'(32'hAA55AA55));
        chk("tbl_param3", 128'(param_o[127:96]), 128'(32'hCAFEF00D));

        // AW first, W three cycles later, CTRL=7
        rs_base = rs_cnt;
        @(negedge clk);
        awaddr = 12'h000; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        chk("aw1_awready", 128'(awready), 128'(0));
        chk("aw1_wready", 128'(wready), 128'(1));
        repeat (2) @(negedge clk);
        wdata = 32'h7; wstrb = 4'hF; wvalid = 1;
        chk("aw1_pre_ctrl", 128'({last_o, run_o, matw_o}), 128'(0));
        @(negedge clk);
        wvalid = 0;
        chk("aw1_ctrl", 128'({last_o, run_o, matw_o}), 128'(3'b111));
        chk("aw1_bvalid", 128'(bvalid), 128'(1));
        chk("aw1_bresp", 128'(bresp), 128'(0));
        chk("aw1_rs_early", 128'(run_start_o), 128'(0));
        @(negedge clk);
        chk("aw1_rs_pulse", 128'(run_start_o), 128'(1));
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk("aw1_rs_done", 128'(run_start_o), 128'(0));
        chk("aw1_bvalid_clr", 128'(bvalid), 128'(0));
        repeat (3) @(negedge clk);
        chk("aw1_rs_count", 128'(rs_cnt - rs_base), 128'(1));

        // W first, then AW, PARAM0
        @(negedge clk);
        awaddr = 12'h008; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1;
        @(negedge clk);
        wvalid = 0;
        chk("w1_wready", 128'(wready), 128'(0));
        chk("w1_awready", 128'(awready), 128'(1));
        chk("w1_pre_param0", 128'(param_o[31:0]), 128'(0));
        @(negedge clk);
        awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        chk("w1_param0", 128'(param_o[31:0]), 128'(32'h12345678));
        chk("w1_bvalid", 128'(bvalid), 128'(1));
        chk("w1_bresp", 128'(bresp), 128'(0));
        bready = 1;
        @(negedge clk);
        bready = 0;

        // matw_clr alone
        @(negedge clk);
        matw_clr = 1;
        @(negedge clk);
        matw_clr = 0;
        chk("clr_matw", 128'(matw_o), 128'(0));
        chk("clr_run_kept", 128'({last_o, run_o}), 128'(2'b11));

        // matw_clr colliding with CTRL write of 1
        @(negedge clk);
        awaddr = 12'h000; awvalid = 1;
        wdata = 32'h1; wstrb = 4'hF; wvalid = 1; matw_clr = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; matw_clr = 0;
        chk("col_ctrl", 128'({last_o, run_o, matw_o}), 128'(3'b001));
        chk("col_bresp", 128'(bresp), 128'(0));
        bready = 1;
        @(negedge clk);
        bready = 0;

        // read/write collision then backpressure
        @(negedge clk);
        awaddr = 12'h010; wdata = 32'h0BADF00D; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        araddr = 12'h010; arvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("bp_rdata_old", 128'(rdata), 128'(0));
        chk("bp_param2", 128'(param_o[95:64]), 128'(32'h0BADF00D));
        wdata = 32'h11111111; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", i), 128'({bvalid, rvalid}), 128'(2'b11));
            chk($sformatf("bp%0d_rdata", i), 128'(rdata), 128'(0));
            chk($sformatf("bp%0d_resp", i), 128'({bresp, rresp}), 128'(0));
            chk($sformatf("bp%0d_awready", i), 128'(awready), 128'(0));
            chk($sformatf("bp%0d_param2", i), 128'(param_o[95:64]),
                128'(32'h0BADF00D));
        end
        bready = 1; rready = 1;
        @(negedge clk);
        bready = 0; rready = 0;
        chk("bp_rel_valid", 128'({bvalid, rvalid}), 128'(0));
        chk("bp_rel_awready", 128'(awready), 128'(1));
        chk("bp_rel_param2", 128'(param_o[95:64]), 128'(32'h0BADF00D));
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("bp_new_bvalid", 128'(bvalid), 128'(1));
        chk("bp_new_param2", 128'(param_o[95:64]), 128'(32'h11111111));
        bready = 1;
        @(negedge clk);
        bready = 0;

        // reset with responses pending
        wr(12'h000, 32'h2, 4'hF, r);
        chk("pre_rst_run", 128'(run_o), 128'(1));
        @(negedge clk);
        awaddr = 12'h008; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        araddr = 12'h008; arvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("pre_rst_valid", 128'({bvalid, rvalid}), 128'(2'b11));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'({bvalid, rvalid}), 128'(0));
        chk("mid_rst_run", 128'(run_o), 128'(0));
        chk("mid_rst_param", param_o, 128'(0));
        chk("mid_rst_ready", 128'({awready, wready, arready}), 128'(3'b111));
        @(negedge clk);
        rst_n = 1'b1;
        rd(12'h008, d, r);
        chk("post_rst_rdata", 128'(d), 128'(0));
        chk("post_rst_rresp", 128'(r), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
